// File: rtl/branch_pkg.sv
// Shared opcodes, counter encodings and helpers for the branch predictor.
// Imported by the condition evaluator and the predictor top.
package branch_pkg;

  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BLEZ = 6'b000110;
  localparam logic [5:0] OP_BGTZ = 6'b000111;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_BLEZ) || (op == OP_BGTZ);
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition and target evaluation.
// Target wraps modulo 2^ADDR_W.
module branch_cond
  import branch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [5:0]        opcode,
  input  logic [31:0]       rs,
  input  logic [31:0]       rt,
  input  logic [15:0]       imm,
  input  logic [ADDR_W-1:0] pc,
  output logic              taken,
  output logic [ADDR_W-1:0] target,
  output logic              is_br
);

  logic signed [17:0] off18;
  logic [ADDR_W-1:0]  off;
  logic               rs_zero;
  logic               rs_neg;

  assign off18   = {imm, 2'b00};
  assign off     = ADDR_W'(off18);
  assign target  = pc + ADDR_W'(4) + off;
  assign is_br   = is_branch(opcode);
  assign rs_zero = (rs == 32'd0);
  assign rs_neg  = rs[31];

  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      opcode == OP_BEQ:  taken = (rs == rt);
      opcode == OP_BNE:  taken = (rs != rt);
      opcode == OP_BLEZ: taken = rs_neg || rs_zero;
      opcode == OP_BGTZ: taken = !rs_neg && !rs_zero;
      default:           taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped tagged 2-bit predictor with execute-stage resolution,
// training, mispredict redirect and saturating statistics.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int BHT_DEPTH = 16,
  parameter int STAT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              predict_taken,
  output logic [ADDR_W-1:0] predict_target,
  input  logic              resolve_valid,
  input  logic [ADDR_W-1:0] resolve_pc,
  input  logic [5:0]        resolve_opcode,
  input  logic [31:0]       resolve_rs_data,
  input  logic [31:0]       resolve_rt_data,
  input  logic [15:0]       resolve_imm,
  input  logic              resolve_pred_taken,
  input  logic [ADDR_W-1:0] resolve_pred_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic              valid_q [BHT_DEPTH];
  logic [TAG_W-1:0]  tag_q   [BHT_DEPTH];
  logic [1:0]        ctr_q   [BHT_DEPTH];
  logic [ADDR_W-1:0] tgt_q   [BHT_DEPTH];

  logic [IDX_W-1:0]  lidx;
  logic [TAG_W-1:0]  ltag;
  logic              lhit;

  assign lidx = lookup_pc[IDX_W+1:2];
  assign ltag = lookup_pc[ADDR_W-1:IDX_W+2];
  assign lhit = valid_q[lidx] && (tag_q[lidx] == ltag);

  assign predict_taken  = lhit && ctr_q[lidx][1];
  assign predict_target = predict_taken ? tgt_q[lidx]
                                        : lookup_pc + ADDR_W'(4);

  logic              act_taken;
  logic [ADDR_W-1:0] act_tgt;
  logic              is_br;

  branch_cond #(.ADDR_W(ADDR_W)) u_cond (
    .opcode (resolve_opcode),
    .rs     (resolve_rs_data),
    .rt     (resolve_rt_data),
    .imm    (resolve_imm),
    .pc     (resolve_pc),
    .taken  (act_taken),
    .target (act_tgt),
    .is_br  (is_br)
  );

  logic [IDX_W-1:0]  ridx;
  logic [TAG_W-1:0]  rtag;
  logic              rhit;
  logic              upd;
  logic              mis;
  logic [ADDR_W-1:0] next_pc;
  logic [1:0]        ctr_cur;
  logic [1:0]        ctr_nxt;

  assign ridx    = resolve_pc[IDX_W+1:2];
  assign rtag    = resolve_pc[ADDR_W-1:IDX_W+2];
  assign rhit    = valid_q[ridx] && (tag_q[ridx] == rtag);
  assign upd     = resolve_valid && is_br;
  assign ctr_cur = ctr_q[ridx];
  assign next_pc = act_taken ? act_tgt : resolve_pc + ADDR_W'(4);

  // Target compare only matters when both sides agree on taken.
  assign mis = upd &&
               ((act_taken != resolve_pred_taken) ||
                (act_taken && (resolve_pred_target != act_tgt)));

  always_comb begin
    ctr_nxt = CTR_WNT;
    if (!rhit)
      ctr_nxt = act_taken ? CTR_WT : CTR_WNT;
    else if (act_taken)
      ctr_nxt = (ctr_cur == CTR_ST) ? CTR_ST : ctr_cur + 2'd1;
    else
      ctr_nxt = (ctr_cur == CTR_SNT) ? CTR_SNT : ctr_cur - 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= CTR_WNT;
        tgt_q[i]   <= '0;
      end
      mispredict       <= 1'b0;
      redirect_pc      <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      mispredict <= mis;
      if (mis)
        redirect_pc <= next_pc;
      if (upd) begin
        valid_q[ridx] <= 1'b1;
        tag_q[ridx]   <= rtag;
        ctr_q[ridx]   <= ctr_nxt;
        tgt_q[ridx]   <= act_tgt;
        if (branch_count != '1)
          branch_count <= branch_count + STAT_W'(1);
      end
      if (mis && (mispredict_count != '1))
        mispredict_count <= mispredict_count + STAT_W'(1);
    end
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch prediction and resolution unit for the pipelined MIPS `cpu`; replaces the fixed single-cycle BEQ/BNE compare in the decode path.
- Holds a direct-mapped table of tagged 2-bit saturating counters plus branch targets.
- Answers fetch-stage lookups in the same cycle.
- Resolves BEQ/BNE/BLEZ/BGTZ from execute-stage operands, trains the table, and flags mispredictions with a redirect PC.
- Keeps saturating branch and misprediction statistics counters.

## Interface
Parameters:
- `ADDR_W`, 32: PC width; PCs are word aligned.
- `BHT_DEPTH`, 16: table entries, power of two ≥ 2; `IDX_W = log2(BHT_DEPTH)`.
- `STAT_W`, 16: width of statistics counters.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset (asserted when 0).
- `lookup_pc`  in  ADDR_W: fetch PC.
- `predict_taken`  out  1: prediction for `lookup_pc` (combinational).
- `predict_target`  out  ADDR_W: predicted next PC (combinational).
- `resolve_valid`  in  1: execute stage holds an instruction to resolve.
- `resolve_pc`  in  ADDR_W: PC of that instruction.
- `resolve_opcode`  in  6: instruction bits [31:26].
- `resolve_rs_data`, `resolve_rt_data`  in  32: operand values.
- `resolve_imm`  in  16: instruction bits [15:0].
- `resolve_pred_taken`  in  1: prediction made at fetch, carried down the pipe.
- `resolve_pred_target`  in  ADDR_W: predicted target, carried down the pipe.
- `mispredict`  out  1: registered one-cycle pulse.
- `redirect_pc`  out  ADDR_W: correct next PC; valid while `mispredict` = 1.
- `branch_count`, `mispredict_count`  out  STAT_W: saturating statistics counters.

## Operation
- Entry fields: `valid`, `tag` (= pc[ADDR_W-1:IDX_W+2]), `ctr[1:0]`, `target[ADDR_W-1:0]`. Index = pc[IDX_W+1:2].
- **Lookup:**
  - Hit = `valid` && tag match.
  - `predict_taken` = hit && `ctr[1]`.
  - `predict_target` = stored target when `predict_taken`, else `lookup_pc + 4`.
- **Branch conditions:**
  - BEQ 000100: rs == rt.
  - BNE 000101: rs != rt.
  - BLEZ 000110: signed rs ≤ 0.
  - BGTZ 000111: signed rs > 0.
- **Actual target** = `resolve_pc + 4 + (sign_ext(imm) << 2)`, truncated to ADDR_W (wraps modulo 2^ADDR_W). Actual next PC = target if taken, else `resolve_pc + 4`.
- **Training** on a branch opcode with `resolve_valid`:
  - On tag miss: allocate the entry with `valid` = 1, new tag, `ctr` = 10 if taken else 01, `target` = actual target.
  - On hit: `ctr` increments if taken (saturates at 11), decrements if not taken (saturates at 00); `target` is rewritten.
- **Mispredict** when `resolved_taken != resolve_pred_taken`, or when both are taken and `resolve_pred_target != actual target`.
- **Non-branch opcode** with `resolve_valid`, or `resolve_valid` = 0: no table update, no statistics change, no `mispredict`.
- **Statistics:** `branch_count` += 1 per resolved branch; `mispredict_count` += 1 per mispredict. Both saturate at all-ones.

## Timing
- Lookup is combinational, zero latency.
- Resolve occurs in cycle N. The table, statistics, `mispredict` and `redirect_pc` update at the end of cycle N and are visible in N+1. `mispredict` is high for exactly one cycle per event.
- If a lookup and an update hit the same index in the same cycle, the lookup returns the pre-update contents (no bypass).
- Back-to-back resolves every cycle are supported; each produces an independent pulse.
- Reset values when `rst` = 0, applied immediately regardless of clock:
  - every entry: `valid` = 0, `ctr` = 01, tag = 0, target = 0;
  - `mispredict` = 0, `redirect_pc` = 0, both statistics counters = 0.
- Reset asserted mid-operation discards any pending pulse. The first resolve after release is treated as a cold miss.

## Structure
- Shared package `branch_pkg`:
  - opcode constants `OP_BEQ`, `OP_BNE`, `OP_BLEZ`, `OP_BGTZ`;
  - counter encodings `CTR_SNT`=00, `CTR_WNT`=01, `CTR_WT`=10, `CTR_ST`=11;
  - the `is_branch` helper.
- One sub-module, `branch_cond`: combinational condition and target evaluation (opcode, rs, rt, imm, pc → taken, target, is_branch).
- The table lives in `branch_predict_unit` as flop arrays, to allow asynchronous reset.

## Test plan
- **Reset:** hold `rst` = 0; lookup PC 0x8 → `predict_taken` 0, `predict_target` 0xC. Both counters read 0; `mispredict` stays 0.
- **Never-taken BNE:** resolve PC 0x8, BNE rs=5 rt=5, imm 0xFFFD, pred 0 → not taken, no mispredict, `branch_count` 1. A subsequent lookup of 0x8 predicts not taken, target 0xC.
- **Taken BNE, cold miss:** resolve PC 0xC, BNE rs=5 rt=0, imm 0xFFFC, pred 0.
  - N+1: `mispredict` 1 and `redirect_pc` 0x0; `mispredict` back to 0 at N+2.
  - Lookup 0xC afterwards → taken, target 0x0.
- **Saturation and hysteresis:** train PC 0x40 BEQ taken ×3 (ctr 11), then not taken ×1 → still predicts taken; a second not taken → predicts not taken.
- **BLEZ/BGTZ signedness:** rs = 0xFFFFFFFF → BLEZ taken, BGTZ not taken. rs = 0 → BLEZ taken, BGTZ not taken.
- **Aliasing and stats:** with `BHT_DEPTH` = 16, resolve 0x10 taken then 0x50 (same index, different tag) → 0x10 lookup misses.
  - Separately, with `STAT_W` = 4, run 20 mispredicts → `mispredict_count` holds at 15.
  - Assert reset during a pending pulse → no pulse after release.
